// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared constants and types for the debounce / synchroniser
//                blocks feeding the synchronous-reset flop.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Legal parameter ranges for the debouncer and its synchroniser
    localparam int SYNC_STAGES_MIN   = 2;
    localparam int SYNC_STAGES_MAX   = 4;
    localparam int STABLE_CYCLES_MAX = 65535;

    // Filter view: IDLE when no candidate change is pending, COUNTING otherwise
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } filter_state_e;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_sync_res_sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_chain
//  Description : Plain multi-flop synchroniser for a single asynchronous bit.
//                No logic sits between the flops, so it is reusable for any
//                clock-domain-crossing input.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    // Shift the raw input one stage per edge; synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/debounce_sync_res.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_sync_res
//  Description : Synchronises a raw bouncing input and qualifies it with a
//                stability counter. q only moves after the synchronised input
//                has disagreed with it for STABLE_CYCLES consecutive edges;
//                rise/fall pulse on the same edge q changes. Legal ranges:
//                SYNC_STAGES 2..4, STABLE_CYCLES 1..65535.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_sync_res
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    // Count value at which the next disagreeing sample commits the change
    localparam logic [CNT_W-1:0] c_last_count = CNT_W'(STABLE_CYCLES - 1);

    logic             w_s;
    logic             w_diff;
    logic             w_done;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             r_rise;
    logic             r_fall;
    filter_state_e    r_state;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (din),
        .q       (w_s)
    );

    // Next-count logic: any agreeing sample restarts qualification from zero
    always_comb begin
        w_diff    = (w_s != r_q);
        w_done    = w_diff && (r_cnt == c_last_count);
        w_cnt_nxt = '0;
        if (w_diff && !w_done) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Filter state, debounced level and registered edge pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_state <= IDLE;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_done & w_s;
            r_fall  <= w_done & ~w_s;
            r_state <= (w_cnt_nxt != '0) ? COUNTING : IDLE;
            if (w_done) begin
                r_q <= w_s;
            end
        end
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = (r_state == COUNTING);

endmodule : debounce_sync_res
`default_nettype wire

// File: tb/tb_debounce_sync_res.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_sync_res
//  Description : Self-checking bench for debounce_sync_res. Three instances
//                (defaults, SYNC_STAGES=3/STABLE_CYCLES=1, STABLE_CYCLES=16)
//                share din/reset_n and are compared each edge against a
//                sliding-window reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_sync_res;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       din;
    logic [2:0] q_v, rise_v, fall_v, busy_v;

    always #5 clk = ~clk;

    debounce_sync_res u_dut0 (
        .clk(clk), .reset_n(reset_n), .din(din),
        .q(q_v[0]), .rise(rise_v[0]), .fall(fall_v[0]), .busy(busy_v[0])
    );

    debounce_sync_res #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .din(din),
        .q(q_v[1]), .rise(rise_v[1]), .fall(fall_v[1]), .busy(busy_v[1])
    );

    debounce_sync_res #(.SYNC_STAGES(2), .STABLE_CYCLES(16)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .din(din),
        .q(q_v[2]), .rise(rise_v[2]), .fall(fall_v[2]), .busy(busy_v[2])
    );

    // Reference model: s is din delayed by SS edges; q flips when the last
    // SC samples of s all disagree with q. busy = newest s disagrees with q.
    int ss [3] = '{2, 3, 2};
    int sc [3] = '{4, 1, 16};
    bit mpipe [3][4];
    bit mhist [3][16];
    bit mq [3];
    bit mr [3];
    bit mf [3];
    bit mb [3];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    function automatic void model_step(int i, bit d, bit rn);
        bit s;
        bit all;
        if (!rn) begin
            for (int k = 0; k < 4; k++)  mpipe[i][k] = 1'b0;
            for (int k = 0; k < 16; k++) mhist[i][k] = 1'b0;
            mq[i] = 1'b0; mr[i] = 1'b0; mf[i] = 1'b0; mb[i] = 1'b0;
            return;
        end
        s = mpipe[i][ss[i]-1];
        for (int k = 3; k > 0; k--)  mpipe[i][k] = mpipe[i][k-1];
        mpipe[i][0] = d;
        for (int k = 15; k > 0; k--) mhist[i][k] = mhist[i][k-1];
        mhist[i][0] = s;
        all = 1'b1;
        for (int k = 0; k < sc[i]; k++) if (mhist[i][k] == mq[i]) all = 1'b0;
        mr[i] = 1'b0;
        mf[i] = 1'b0;
        if (all) begin
            mq[i] = ~mq[i];
            mr[i] = mq[i];
            mf[i] = ~mq[i];
        end
        mb[i] = (mhist[i][0] != mq[i]);
    endfunction

    task automatic check_vec(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: q/rise/fall/busy got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge with the given inputs; all instances checked vs model
    task automatic tick(input bit d, input bit rn);
        din     = d;
        reset_n = rn;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, d, rn);
        #1;
        for (int i = 0; i < 3; i++)
            check_vec($sformatf("model inst%0d cyc%0d", i, cyc),
                      {q_v[i], rise_v[i], fall_v[i], busy_v[i]},
                      {mq[i], mr[i], mf[i], mb[i]});
        cyc++;
    endtask

    typedef struct {
        bit         rn;
        bit         d;
        logic [3:0] exp;   // {q, rise, fall, busy} of the default instance
    } vec_t;

    vec_t tbl [17];
    int   first [3];
    int   rises;
    int   bcnt;
    bit   rd;
    int   rate;

    initial begin
        din     = 1'b1;
        reset_n = 1'b0;

        // Reset with din=1, release, clean rise then clean fall (defaults)
        tbl[0]  = '{1'b0, 1'b1, 4'b0000};
        tbl[1]  = '{1'b0, 1'b1, 4'b0000};
        tbl[2]  = '{1'b0, 1'b1, 4'b0000};
        tbl[3]  = '{1'b1, 1'b1, 4'b0000};
        tbl[4]  = '{1'b1, 1'b1, 4'b0000};
        tbl[5]  = '{1'b1, 1'b1, 4'b0001};
        tbl[6]  = '{1'b1, 1'b1, 4'b0001};
        tbl[7]  = '{1'b1, 1'b1, 4'b0001};
        tbl[8]  = '{1'b1, 1'b1, 4'b1100};
        tbl[9]  = '{1'b1, 1'b1, 4'b1000};
        tbl[10] = '{1'b1, 1'b0, 4'b1000};
        tbl[11] = '{1'b1, 1'b0, 4'b1000};
        tbl[12] = '{1'b1, 1'b0, 4'b1001};
        tbl[13] = '{1'b1, 1'b0, 4'b1001};
        tbl[14] = '{1'b1, 1'b0, 4'b1001};
        tbl[15] = '{1'b1, 1'b0, 4'b0010};
        tbl[16] = '{1'b1, 1'b0, 4'b0000};

        for (int k = 0; k < 17; k++) begin
            tick(tbl[k].d, tbl[k].rn);
            check_vec($sformatf("table row%0d", k),
                      {q_v[0], rise_v[0], fall_v[0], busy_v[0]}, tbl[k].exp);
        end

        // Glitch: 3 cycles high is rejected, busy for exactly 3 cycles
        repeat (20) tick(1'b0, 1'b1);
        rises = 0; bcnt = 0;
        for (int k = 0; k < 23; k++) begin
            tick(k < 3, 1'b1);
            rises += rise_v[0];
            bcnt  += busy_v[0];
        end
        check_int("glitch rises", rises, 0);
        check_int("glitch busy cycles", bcnt, 3);
        check_int("glitch q", q_v[0], 0);

        // Bounce 1,1,0,1,1,1,1 then hold: one rise once the last run qualifies
        begin
            bit bpat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            rises = 0; first[0] = -1;
            for (int k = 0; k < 17; k++) begin
                tick((k < 7) ? bpat[k] : 1'b1, 1'b1);
                if (rise_v[0]) begin
                    rises++;
                    if (first[0] < 0) first[0] = k;
                end
            end
            check_int("bounce rise count", rises, 1);
            check_int("bounce rise edge", first[0], 8);
        end

        // Reset mid-count discards progress; full latency after release
        repeat (20) tick(1'b0, 1'b1);
        repeat (4) tick(1'b1, 1'b1);
        check_int("midcount busy before reset", busy_v[0], 1);
        tick(1'b1, 1'b0);
        check_vec("midcount in reset",
                  {q_v[0], rise_v[0], fall_v[0], busy_v[0]}, 4'b0000);
        first[0] = -1;
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b1);
            if (rise_v[0] && first[0] < 0) first[0] = k;
        end
        check_int("midcount rise edge after release", first[0], 5);

        // Step latency on all three parameter sets; busy never set for SC=1
        repeat (30) tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) first[i] = -1;
        bcnt = 0;
        for (int k = 0; k < 25; k++) begin
            tick(1'b1, 1'b1);
            for (int i = 0; i < 3; i++)
                if (rise_v[i] && first[i] < 0) first[i] = k;
            bcnt += busy_v[1];
        end
        check_int("latency default", first[0], 5);
        check_int("latency ss3 sc1", first[1], 3);
        check_int("latency sc16", first[2], 17);
        check_int("sc1 busy cycles", bcnt, 0);

        // 15-cycle glitch rejected with STABLE_CYCLES=16
        repeat (30) tick(1'b0, 1'b1);
        rises = 0;
        for (int k = 0; k < 45; k++) begin
            tick(k < 15, 1'b1);
            rises += rise_v[2];
        end
        check_int("sc16 15-cycle glitch rises", rises, 0);

        // Randomised din with varying bounce rate and occasional resets
        rd = 1'b0;
        rate = 4;
        for (int k = 0; k < 2400; k++) begin
            if (k % 200 == 0) rate = $urandom_range(1, 24);
            if ($urandom_range(0, rate - 1) == 0) rd = ~rd;
            tick(rd, ($urandom_range(0, 149) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_debounce_sync_res
`default_nettype wire
